// File: rtl/mem_stage_pkg.sv
// Shared types and reset values for the MEM pipeline stage.
// The optional LWL/LWR merge support is enabled with MEM_LWLR_EN.
package mem_stage_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LB      = 3'd1,
        LBU     = 3'd2,
        LH      = 3'd3,
        LHU     = 3'd4,
        LW      = 3'd5,
        LWL     = 3'd6,
        LWR     = 3'd7
    } load_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // non-load, or nothing held
        ST_WAIT = 2'd1,   // load issued, read data not yet returned
        ST_HOLD = 2'd2    // read data captured, WB not yet accepting
    } mem_state_e;

    localparam logic [31:0] MEM_RST_WORD  = 32'h0;
    localparam logic [3:0]  MEM_RST_WE    = 4'h0;
    localparam logic [4:0]  MEM_RST_WNUM  = 5'h0;
    localparam logic [2:0]  MEM_RST_WTYPE = 3'h0;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment and extension; LWL/LWR byte merging when MEM_LWLR_EN is defined.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] src,
    input  logic [1:0]  off,
    input  load_type_e  load_type,
    input  logic [31:0] rt_data,
    output logic [31:0] wbdata,
    output logic [3:0]  we
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = src[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? src[31:16] : src[15:0];

`ifdef MEM_LWLR_EN
    logic [1:0]  inv_off;
    logic [31:0] lwl_data;
    logic [31:0] lwr_data;
    logic [3:0]  lwl_we;
    logic [3:0]  lwr_we;
    logic [31:0] merge_data;
    logic [3:0]  merge_we;

    assign inv_off  = 2'd3 - off;
    assign lwl_data = src << {inv_off, 3'b000};
    assign lwr_data = src >> {off, 3'b000};
    assign lwl_we   = 4'hF << inv_off;
    assign lwr_we   = 4'hF >> off;
    assign merge_we   = (load_type == LWL) ? lwl_we : lwr_we;
    assign merge_data = (load_type == LWL) ? lwl_data : lwr_data;
`else
    logic unused_rt;
    assign unused_rt = ^rt_data;
`endif

    always_comb begin
        wbdata = src;
        we     = 4'hF;
        case (load_type)
            LB:  wbdata = {{24{byte_sel[7]}}, byte_sel};
            LBU: wbdata = {24'h0, byte_sel};
            LH:  wbdata = {{16{half_sel[15]}}, half_sel};
            LHU: wbdata = {16'h0, half_sel};
`ifdef MEM_LWLR_EN
            LWL, LWR: begin
                // Unwritten bytes carry old rt so forwarding sees the full merged word
                for (int b = 0; b < 4; b++)
                    wbdata[8*b +: 8] = merge_we[b] ? merge_data[8*b +: 8] : rt_data[8*b +: 8];
                we = merge_we;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits on data-SRAM load responses, aligns load data and
// presents the writeback bundle to WB. Optional LWL/LWR support: MEM_LWLR_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          exe_valid_in,
    output logic          mem_allowin_out,
    input  logic [DW-1:0] exe_PC_in,
    input  logic [DW-1:0] exe_result_in,
    input  logic [DW-1:0] exe_rt_data_in,
    input  logic [2:0]    exe_load_type_in,
    input  logic [3:0]    exe_reg_we_in,
    input  logic [4:0]    exe_wnum_in,
    input  logic [2:0]    exe_write_type_in,
    input  logic          data_rdata_ok_in,
    input  logic [DW-1:0] data_rdata_in,
    input  logic          wb_allowin_in,
    output logic          mem_valid_out,
    output logic [DW-1:0] mem_wbdata_out,
    output logic [3:0]    mem_reg_we_out,
    output logic [4:0]    mem_wnum_out,
    output logic [2:0]    mem_write_type_out,
    output logic [DW-1:0] mem_PC_out,
    output logic [3:0]    mem_fwd_we_out,
    output logic          mem_load_pending_out
);

    logic          valid_r;
    mem_state_e    state;
    logic [DW-1:0] pc_r;
    logic [DW-1:0] result_r;
    logic [DW-1:0] rt_r;
    logic [DW-1:0] rdata_r;
    load_type_e    ltype_r;
    logic [3:0]    we_r;
    logic [4:0]    wnum_r;
    logic [2:0]    wtype_r;

    logic          ready;
    logic          allowin;
    logic          is_load;
    logic [DW-1:0] src;
    logic [DW-1:0] align_data;
    logic [3:0]    align_we;

    // Returning data in WAIT makes the stage ready the same cycle (no bubble).
    assign ready   = (state != ST_WAIT) || data_rdata_ok_in;
    assign allowin = !valid_r || (ready && wb_allowin_in);
    assign is_load = (ltype_r != LD_NONE);
    assign src     = (state == ST_WAIT) ? data_rdata_in : rdata_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r  <= 1'b0;
            state    <= ST_IDLE;
            pc_r     <= MEM_RST_WORD;
            result_r <= MEM_RST_WORD;
            rt_r     <= MEM_RST_WORD;
            rdata_r  <= MEM_RST_WORD;
            ltype_r  <= LD_NONE;
            we_r     <= MEM_RST_WE;
            wnum_r   <= MEM_RST_WNUM;
            wtype_r  <= MEM_RST_WTYPE;
        end else begin
            if (allowin) begin
                valid_r <= exe_valid_in;
                if (exe_valid_in) begin
                    pc_r     <= exe_PC_in;
                    result_r <= exe_result_in;
                    rt_r     <= exe_rt_data_in;
                    ltype_r  <= load_type_e'(exe_load_type_in);
                    we_r     <= exe_reg_we_in;
                    wnum_r   <= exe_wnum_in;
                    wtype_r  <= exe_write_type_in;
                end
                state <= (exe_valid_in && load_type_e'(exe_load_type_in) != LD_NONE) ? ST_WAIT : ST_IDLE;
            end else if (state == ST_WAIT && data_rdata_ok_in) begin
                rdata_r <= data_rdata_in;
                state   <= ST_HOLD;
            end
        end
    end

    mem_stage_load_align u_align (
        .src       (src),
        .off       (result_r[1:0]),
        .load_type (ltype_r),
        .rt_data   (rt_r),
        .wbdata    (align_data),
        .we        (align_we)
    );

    assign mem_allowin_out      = allowin;
    assign mem_valid_out        = valid_r && ready;
    assign mem_wbdata_out       = is_load ? align_data : result_r;
    assign mem_reg_we_out       = is_load ? align_we : we_r;
    assign mem_wnum_out         = wnum_r;
    assign mem_write_type_out   = wtype_r;
    assign mem_PC_out           = pc_r;
    assign mem_fwd_we_out       = mem_valid_out ? mem_reg_we_out : 4'h0;
    assign mem_load_pending_out = valid_r && (state == ST_WAIT);

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (LWL/LWR cases follow MEM_LWLR_EN).
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        exe_valid_in;
    logic        mem_allowin_out;
    logic [31:0] exe_PC_in;
    logic [31:0] exe_result_in;
    logic [31:0] exe_rt_data_in;
    logic [2:0]  exe_load_type_in;
    logic [3:0]  exe_reg_we_in;
    logic [4:0]  exe_wnum_in;
    logic [2:0]  exe_write_type_in;
    logic        data_rdata_ok_in;
    logic [31:0] data_rdata_in;
    logic        wb_allowin_in;
    logic        mem_valid_out;
    logic [31:0] mem_wbdata_out;
    logic [3:0]  mem_reg_we_out;
    logic [4:0]  mem_wnum_out;
    logic [2:0]  mem_write_type_out;
    logic [31:0] mem_PC_out;
    logic [3:0]  mem_fwd_we_out;
    logic        mem_load_pending_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .exe_valid_in         (exe_valid_in),
        .mem_allowin_out      (mem_allowin_out),
        .exe_PC_in            (exe_PC_in),
        .exe_result_in        (exe_result_in),
        .exe_rt_data_in       (exe_rt_data_in),
        .exe_load_type_in     (exe_load_type_in),
        .exe_reg_we_in        (exe_reg_we_in),
        .exe_wnum_in          (exe_wnum_in),
        .exe_write_type_in    (exe_write_type_in),
        .data_rdata_ok_in     (data_rdata_ok_in),
        .data_rdata_in        (data_rdata_in),
        .wb_allowin_in        (wb_allowin_in),
        .mem_valid_out        (mem_valid_out),
        .mem_wbdata_out       (mem_wbdata_out),
        .mem_reg_we_out       (mem_reg_we_out),
        .mem_wnum_out         (mem_wnum_out),
        .mem_write_type_out   (mem_write_type_out),
        .mem_PC_out           (mem_PC_out),
        .mem_fwd_we_out       (mem_fwd_we_out),
        .mem_load_pending_out (mem_load_pending_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] lt, input logic [31:0] pc, input logic [31:0] res,
                         input logic [3:0] we, input logic [4:0] wn, input logic [31:0] rt);
        exe_valid_in      = 1'b1;
        exe_load_type_in  = lt;
        exe_PC_in         = pc;
        exe_result_in     = res;
        exe_reg_we_in     = we;
        exe_wnum_in       = wn;
        exe_write_type_in = 3'd2;
        exe_rt_data_in    = rt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        exe_valid_in = 1'b0; exe_PC_in = '0; exe_result_in = '0; exe_rt_data_in = '0;
        exe_load_type_in = LD_NONE; exe_reg_we_in = '0; exe_wnum_in = '0; exe_write_type_in = '0;
        data_rdata_ok_in = 1'b0; data_rdata_in = '0; wb_allowin_in = 1'b1;
        #12;
        checks++;
        if (mem_valid_out !== 1'b0 || mem_reg_we_out !== 4'h0 || mem_fwd_we_out !== 4'h0 ||
            mem_load_pending_out !== 1'b0 || mem_wbdata_out !== 32'h0 || mem_PC_out !== 32'h0 ||
            mem_wnum_out !== 5'd0 || mem_allowin_out !== 1'b1) begin
            errors++;
            $display("FAIL reset: valid=%b we=%h fwd=%h pend=%b data=%h pc=%h wnum=%0d allowin=%b (want 0,0,0,0,0,0,0,1)",
                     mem_valid_out, mem_reg_we_out, mem_fwd_we_out, mem_load_pending_out,
                     mem_wbdata_out, mem_PC_out, mem_wnum_out, mem_allowin_out);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_alu();
        issue(LD_NONE, 32'hBFC00000, 32'h1234, 4'hF, 5'd3, 32'h0);
        #1;
        checks++;
        if (mem_allowin_out !== 1'b1) begin
            errors++; $display("FAIL alu_allowin: got %b want 1", mem_allowin_out);
        end
        step();
        exe_valid_in = 1'b0;
        #1;
        checks++;
        if (mem_valid_out !== 1'b1 || mem_wbdata_out !== 32'h1234 || mem_reg_we_out !== 4'hF ||
            mem_wnum_out !== 5'd3 || mem_PC_out !== 32'hBFC00000 || mem_write_type_out !== 3'd2) begin
            errors++;
            $display("FAIL alu_out: valid=%b data=%h we=%h wnum=%0d pc=%h wt=%0d want 1,1234,f,3,bfc00000,2",
                     mem_valid_out, mem_wbdata_out, mem_reg_we_out, mem_wnum_out, mem_PC_out, mem_write_type_out);
        end
        checks++;
        if (mem_fwd_we_out !== 4'hF || mem_load_pending_out !== 1'b0) begin
            errors++; $display("FAIL alu_fwd: fwd=%h pend=%b want f,0", mem_fwd_we_out, mem_load_pending_out);
        end
        step();
        checks++;
        if (mem_valid_out !== 1'b0 || mem_fwd_we_out !== 4'h0) begin
            errors++; $display("FAIL alu_drain: valid=%b fwd=%h want 0,0", mem_valid_out, mem_fwd_we_out);
        end
    endtask

    task automatic test_byte();
        issue(LB, 32'h100, 32'h1002, 4'hF, 5'd4, 32'h0);
        step();
        exe_valid_in = 1'b0;
        #1;
        checks++;
        if (mem_load_pending_out !== 1'b1 || mem_valid_out !== 1'b0 || mem_fwd_we_out !== 4'h0) begin
            errors++; $display("FAIL lb_wait: pend=%b valid=%b fwd=%h want 1,0,0",
                               mem_load_pending_out, mem_valid_out, mem_fwd_we_out);
        end
        data_rdata_ok_in = 1'b1; data_rdata_in = 32'h00800000;
        // LBU follows back-to-back while LB's data returns
        issue(LBU, 32'h104, 32'h2002, 4'hF, 5'd5, 32'h0);
        #1;
        checks++;
        if (mem_valid_out !== 1'b1 || mem_wbdata_out !== 32'hFFFFFF80 || mem_reg_we_out !== 4'hF ||
            mem_allowin_out !== 1'b1) begin
            errors++; $display("FAIL lb_data: valid=%b data=%h we=%h allowin=%b want 1,ffffff80,f,1",
                               mem_valid_out, mem_wbdata_out, mem_reg_we_out, mem_allowin_out);
        end
        step();
        exe_valid_in = 1'b0;
        #1;
        checks++;
        if (mem_wbdata_out !== 32'h00000080 || mem_valid_out !== 1'b1 || mem_wnum_out !== 5'd5) begin
            errors++; $display("FAIL lbu_data: data=%h valid=%b wnum=%0d want 00000080,1,5",
                               mem_wbdata_out, mem_valid_out, mem_wnum_out);
        end
        step();
        data_rdata_ok_in = 1'b0;
    endtask

    task automatic test_half();
        issue(LH, 32'h200, 32'h3002, 4'hF, 5'd0, 32'h0);
        step();
        exe_valid_in = 1'b0;
        data_rdata_ok_in = 1'b1; data_rdata_in = 32'h80011234;
        #1;
        checks++;
        if (mem_wbdata_out !== 32'hFFFF8001 || mem_wnum_out !== 5'd0 || mem_valid_out !== 1'b1) begin
            errors++; $display("FAIL lh_data: data=%h wnum=%0d valid=%b want ffff8001,0,1",
                               mem_wbdata_out, mem_wnum_out, mem_valid_out);
        end
        issue(LHU, 32'h204, 32'h3000, 4'hF, 5'd6, 32'h0);
        step();
        exe_valid_in = 1'b0;
        #1;
        checks++;
        if (mem_wbdata_out !== 32'h00001234) begin
            errors++; $display("FAIL lhu_data: data=%h want 00001234", mem_wbdata_out);
        end
        step();
        data_rdata_ok_in = 1'b0;
    endtask

    task automatic test_lw_delay();
        issue(LW, 32'h300, 32'h4000, 4'hF, 5'd7, 32'h0);
        step();
        exe_valid_in = 1'b0;
        data_rdata_in = 32'h13572468;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (mem_allowin_out !== 1'b0 || mem_load_pending_out !== 1'b1 || mem_valid_out !== 1'b0) begin
                errors++; $display("FAIL lw_stall[%0d]: allowin=%b pend=%b valid=%b want 0,1,0",
                                   i, mem_allowin_out, mem_load_pending_out, mem_valid_out);
            end
            step();
        end
        data_rdata_ok_in = 1'b1; data_rdata_in = 32'hDEADBEEF;
        #1;
        checks++;
        if (mem_valid_out !== 1'b1 || mem_wbdata_out !== 32'hDEADBEEF || mem_fwd_we_out !== 4'hF ||
            mem_allowin_out !== 1'b1) begin
            errors++; $display("FAIL lw_data: valid=%b data=%h fwd=%h allowin=%b want 1,deadbeef,f,1",
                               mem_valid_out, mem_wbdata_out, mem_fwd_we_out, mem_allowin_out);
        end
        step();
        data_rdata_ok_in = 1'b0;
    endtask

    task automatic test_hold();
        issue(LW, 32'h400, 32'h5000, 4'hF, 5'd8, 32'h0);
        step();
        exe_valid_in = 1'b0;
        wb_allowin_in = 1'b0;
        data_rdata_ok_in = 1'b1; data_rdata_in = 32'h11112222;
        #1;
        checks++;
        if (mem_allowin_out !== 1'b0) begin
            errors++; $display("FAIL hold_block: allowin=%b want 0", mem_allowin_out);
        end
        step();
        data_rdata_ok_in = 1'b0; data_rdata_in = 32'h99999999;
        #1;
        checks++;
        if (mem_valid_out !== 1'b1 || mem_wbdata_out !== 32'h11112222 || mem_load_pending_out !== 1'b0 ||
            mem_allowin_out !== 1'b0) begin
            errors++; $display("FAIL hold_data: valid=%b data=%h pend=%b allowin=%b want 1,11112222,0,0",
                               mem_valid_out, mem_wbdata_out, mem_load_pending_out, mem_allowin_out);
        end
        // a stray response while holding must not overwrite the captured word
        data_rdata_ok_in = 1'b1; data_rdata_in = 32'h55555555;
        step();
        data_rdata_ok_in = 1'b0;
        #1;
        checks++;
        if (mem_wbdata_out !== 32'h11112222) begin
            errors++; $display("FAIL hold_stray: data=%h want 11112222", mem_wbdata_out);
        end
        wb_allowin_in = 1'b1;
        #1;
        checks++;
        if (mem_allowin_out !== 1'b1 || mem_valid_out !== 1'b1) begin
            errors++; $display("FAIL hold_release: allowin=%b valid=%b want 1,1", mem_allowin_out, mem_valid_out);
        end
        step();
        checks++;
        if (mem_valid_out !== 1'b0) begin
            errors++; $display("FAIL hold_drain: valid=%b want 0", mem_valid_out);
        end
    endtask

    task automatic test_lwlr();
        issue(LWL, 32'h500, 32'h6001, 4'hF, 5'd9, 32'h11223344);
        step();
        exe_valid_in = 1'b0;
        data_rdata_ok_in = 1'b1; data_rdata_in = 32'hAABBCCDD;
        #1;
        checks++;
`ifdef MEM_LWLR_EN
        if (mem_wbdata_out !== 32'hCCDD3344 || mem_reg_we_out !== 4'b1100 || mem_fwd_we_out !== 4'b1100) begin
            errors++; $display("FAIL lwl: data=%h we=%b fwd=%b want ccdd3344,1100,1100",
                               mem_wbdata_out, mem_reg_we_out, mem_fwd_we_out);
        end
`else
        if (mem_wbdata_out !== 32'hAABBCCDD || mem_reg_we_out !== 4'b1111) begin
            errors++; $display("FAIL lwl_as_lw: data=%h we=%b want aabbccdd,1111", mem_wbdata_out, mem_reg_we_out);
        end
`endif
        issue(LWR, 32'h504, 32'h6005, 4'hF, 5'd10, 32'h11223344);
        step();
        exe_valid_in = 1'b0;
        #1;
        checks++;
`ifdef MEM_LWLR_EN
        if (mem_wbdata_out !== 32'h11AABBCC || mem_reg_we_out !== 4'b0111) begin
            errors++; $display("FAIL lwr: data=%h we=%b want 11aabbcc,0111", mem_wbdata_out, mem_reg_we_out);
        end
`else
        if (mem_wbdata_out !== 32'hAABBCCDD || mem_reg_we_out !== 4'b1111) begin
            errors++; $display("FAIL lwr_as_lw: data=%h we=%b want aabbccdd,1111", mem_wbdata_out, mem_reg_we_out);
        end
`endif
        step();
        data_rdata_ok_in = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        issue(LW, 32'h600, 32'h7000, 4'hF, 5'd11, 32'h0);
        step();
        exe_valid_in = 1'b0;
        #1;
        checks++;
        if (mem_load_pending_out !== 1'b1) begin
            errors++; $display("FAIL rst_pre: pend=%b want 1", mem_load_pending_out);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (mem_valid_out !== 1'b0 || mem_load_pending_out !== 1'b0 || mem_allowin_out !== 1'b1) begin
            errors++; $display("FAIL rst_async: valid=%b pend=%b allowin=%b want 0,0,1",
                               mem_valid_out, mem_load_pending_out, mem_allowin_out);
        end
        rst = 1'b0;
        data_rdata_ok_in = 1'b1; data_rdata_in = 32'hCAFEF00D;
        step();
        data_rdata_ok_in = 1'b0;
        #1;
        checks++;
        if (mem_valid_out !== 1'b0 || mem_wbdata_out !== 32'h0 || mem_reg_we_out !== 4'h0 ||
            mem_load_pending_out !== 1'b0) begin
            errors++; $display("FAIL rst_stray: valid=%b data=%h we=%h pend=%b want 0,0,0,0",
                               mem_valid_out, mem_wbdata_out, mem_reg_we_out, mem_load_pending_out);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_byte();
        test_half();
        test_lw_delay();
        test_hold();
        test_lwlr();
        test_reset_mid_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
